// File: rtl/ddr3_wr_queue.sv
// Posted-write FIFO ahead of the DDR3 controller write agent.
// The head entry is shown combinationally on WrAddr/WrData and retired on each WrGnt.
module ddr3_wr_queue #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AFULL  = 12
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       flush,
  output logic                       WrReq,
  input  logic                       WrGnt,
  output logic [ADDR_W-1:0]          WrAddr,
  output logic [DATA_W-1:0]          WrData,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic                       err_gnt
);
  localparam int L = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [L-1:0] PTR_ONE = L'(1);
  localparam logic [L:0]   LVL_ONE = (L+1)'(1);
  localparam logic [L:0]   LVL_MAX = (L+1)'(DEPTH);
  localparam logic [L:0]   LVL_AF  = (L+1)'(AFULL);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [L-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [L:0]       level_q, level_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  assign empty       = (level_q == '0);
  assign full        = (level_q == LVL_MAX);
  assign almost_full = (level_q >= LVL_AF);
  assign level       = level_q;
  assign err_gnt     = err_q;

  assign wr_ready = resetn & ~full & ~flush;
  assign WrReq    = ~empty;
  // Flush masks the grant so a discarded head is never counted as popped.
  assign push     = wr_valid & wr_ready;
  assign pop      = WrGnt & WrReq & ~flush;

  assign head   = empty ? '0 : mem_q[rd_ptr_q];
  assign WrAddr = head[ENT_W-1:DATA_W];
  assign WrData = head[DATA_W-1:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    err_d    = err_q | (WrGnt & empty);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

  // Storage is deliberately left unreset; only the pointers give it meaning.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data};
  end
endmodule

// File: tb/tb_ddr3_wr_queue.sv
// Directed bench for ddr3_wr_queue with hand-computed expectations.
module tb_ddr3_wr_queue;
  logic        clk = 1'b0;
  logic        resetn;
  logic        wr_valid;
  logic        wr_ready;
  logic [27:0] wr_addr;
  logic [15:0] wr_data;
  logic        flush;
  logic        WrReq;
  logic        WrGnt;
  logic [27:0] WrAddr;
  logic [15:0] WrData;
  logic [4:0]  level;
  logic        empty, full, almost_full, err_gnt;

  int errors = 0;
  int checks = 0;

  ddr3_wr_queue #(.ADDR_W(28), .DATA_W(16), .DEPTH(16), .AFULL(12)) dut (
    .clk(clk), .resetn(resetn), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .WrReq(WrReq),
    .WrGnt(WrGnt), .WrAddr(WrAddr), .WrData(WrData), .level(level),
    .empty(empty), .full(full), .almost_full(almost_full), .err_gnt(err_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [27:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    flush = 1'b0; WrGnt = 1'b0;
    step(); step();
    chk("rst_wrreq",  64'(WrReq), 64'(0));
    chk("rst_ready",  64'(wr_ready), 64'(0));
    chk("rst_level",  64'(level), 64'(0));
    chk("rst_empty",  64'(empty), 64'(1));
    chk("rst_full",   64'(full), 64'(0));
    chk("rst_af",     64'(almost_full), 64'(0));
    chk("rst_err",    64'(err_gnt), 64'(0));
    chk("rst_addr",   64'(WrAddr), 64'(0));
    chk("rst_data",   64'(WrData), 64'(0));
    resetn = 1'b1;
    #1;
    chk("rel_ready",  64'(wr_ready), 64'(1));

    // single push: no flow-through, visible next cycle
    wr_valid = 1'b1; wr_addr = 28'h000_0400; wr_data = 16'hA5A5;
    #1;
    chk("t1_noflow",  64'(WrReq), 64'(0));
    step();
    wr_valid = 1'b0;
    chk("t1_req",     64'(WrReq), 64'(1));
    chk("t1_addr",    64'(WrAddr), 64'(28'h000_0400));
    chk("t1_data",    64'(WrData), 64'(16'hA5A5));
    chk("t1_level",   64'(level), 64'(1));
    WrGnt = 1'b1;
    step();
    WrGnt = 1'b0;
    chk("t1_req0",    64'(WrReq), 64'(0));
    chk("t1_addr0",   64'(WrAddr), 64'(0));
    chk("t1_level0",  64'(level), 64'(0));

    // fill to full, watch almost_full threshold
    for (int i = 0; i < 16; i++) begin
      push_one(28'(i + 'h100), 16'(i));
      chk("t2_level", 64'(level), 64'(i + 1));
      chk("t2_af",    64'(almost_full), 64'((i + 1) >= 12));
    end
    chk("t2_full",    64'(full), 64'(1));
    chk("t2_ready",   64'(wr_ready), 64'(0));
    push_one(28'h999, 16'h0099);
    chk("t2_17th",    64'(level), 64'(16));
    WrGnt = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_req",  64'(WrReq), 64'(1));
      chk("t2_data", 64'(WrData), 64'(i));
      chk("t2_addr", 64'(WrAddr), 64'(i + 'h100));
      step();
    end
    WrGnt = 1'b0;
    chk("t2_empty",   64'(empty), 64'(1));

    // steady push+pop at level 3 across pointer wrap
    for (int k = 0; k < 3; k++) push_one(28'(k), 16'('h200 + k));
    chk("t3_level0",  64'(level), 64'(3));
    for (int c = 0; c < 40; c++) begin
      wr_valid = 1'b1; wr_addr = 28'(c + 3); wr_data = 16'('h200 + c + 3);
      WrGnt = 1'b1;
      chk("t3_head", 64'(WrData), 64'('h200 + c));
      step();
      chk("t3_level", 64'(level), 64'(3));
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_tail", 64'(WrData), 64'('h200 + 40 + k));
      step();
    end
    WrGnt = 1'b0;
    chk("t3_empty",   64'(empty), 64'(1));

    // grant while empty
    WrGnt = 1'b1;
    step();
    WrGnt = 1'b0;
    chk("t4_err",     64'(err_gnt), 64'(1));
    chk("t4_level",   64'(level), 64'(0));
    step();
    chk("t4_sticky",  64'(err_gnt), 64'(1));
    push_one(28'h77, 16'h0077);
    chk("t4_data",    64'(WrData), 64'(16'h0077));
    WrGnt = 1'b1;
    step();
    WrGnt = 1'b0;
    chk("t4_empty",   64'(empty), 64'(1));

    // flush with simultaneous grant
    for (int k = 0; k < 5; k++) push_one(28'(k), 16'('h300 + k));
    chk("t5_level5",  64'(level), 64'(5));
    flush = 1'b1; WrGnt = 1'b1;
    #1;
    chk("t5_ready",   64'(wr_ready), 64'(0));
    step();
    flush = 1'b0; WrGnt = 1'b0;
    chk("t5_level",   64'(level), 64'(0));
    chk("t5_req",     64'(WrReq), 64'(0));
    chk("t5_err",     64'(err_gnt), 64'(1));
    push_one(28'h55, 16'h0055);
    chk("t5_after",   64'(WrData), 64'(16'h0055));
    WrGnt = 1'b1;
    step();
    WrGnt = 1'b0;

    // asynchronous reset mid-stream
    for (int k = 0; k < 7; k++) push_one(28'(k), 16'('h400 + k));
    chk("t6_level7",  64'(level), 64'(7));
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_req",     64'(WrReq), 64'(0));
    chk("t6_level",   64'(level), 64'(0));
    chk("t6_addr",    64'(WrAddr), 64'(0));
    chk("t6_err",     64'(err_gnt), 64'(0));
    chk("t6_ready",   64'(wr_ready), 64'(0));
    step();
    resetn = 1'b1;
    push_one(28'hABC, 16'hBEEF);
    chk("t6_preq",    64'(WrReq), 64'(1));
    chk("t6_paddr",   64'(WrAddr), 64'(28'hABC));
    chk("t6_pdata",   64'(WrData), 64'(16'hBEEF));
    chk("t6_plevel",  64'(level), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
